adc_range_monitor: RTL and testbench
====================================

Name: adc_range_monitor

Overview:
Consumes one fast-ADC channel in the ADC clock domain, the same 16-bit signed samples that feed the lock-in data processor. Over fixed windows of 2^WINDOW_LOG2 samples it tracks the signed minimum, signed maximum and saturation count, then publishes them with a one-cycle valid strobe. It also drives an instantaneous saturation flag and a stretched saturation LED for the board status LEDs.

Parameters:
DATA_W, 16, sample width, two's complement
WINDOW_LOG2, 20, window length = 2^WINDOW_LOG2 valid samples
STRETCH_CYCLES, 5_000_000, LED hold time in clk_50 cycles (100 ms at 50 MHz)
SAT_CNT_W, 16, width of the saturation counter

Ports:
clk_50  in  1  ADC output clock, 50 MHz
reset  in  1  asynchronous, active-high
sample_valid  in  1  sample_data qualifier
sample_data  in  DATA_W  signed ADC sample
clear  in  1  synchronous restart of the current window
win_min  out  DATA_W  signed minimum of the last completed window
win_max  out  DATA_W  signed maximum of the last completed window
win_sat_count  out  SAT_CNT_W  saturated samples in the last completed window
win_valid  out  1  one-cycle pulse when the win_* outputs update
saturating  out  1  registered flag: last valid sample was saturated
sat_led  out  1  stretched saturation indicator

Behaviour:
- Reset (asynchronous, any time): all outputs 0. FSM goes to S_SEED. Sample counter, accumulators and stretch counter all go to 0.
- Saturation is defined as sample_data == {0,1...1} (16'h7FFF) or {1,0...0} (16'h8000).
- FSM states:
  - S_SEED: waits for sample_valid. The first valid sample loads acc_min = acc_max = sample, acc_sat = sat, count = 1, then goes to S_ACCUM.
  - S_ACCUM: on each valid sample, acc_min/acc_max update by signed compare, acc_sat += sat, count += 1.
  - When the sample completing the window arrives (count == 2^WINDOW_LOG2 - 1 with valid), it is included and the FSM goes to S_PUBLISH.
  - S_PUBLISH: exactly one cycle. win_* <= acc_*, win_valid = 1, then back to S_SEED.
- A sample_valid during S_PUBLISH is not lost. It seeds the next window in that same cycle and the FSM goes to S_ACCUM, so there is no gap between windows.
- Latency: win_valid is asserted on the cycle after the clock edge that captured the last sample of the window. win_* hold their value until the next publish.
- acc_sat saturates at all-ones and never wraps. The count is WINDOW_LOG2+1 bits wide.
- clear:
  - Acts in any state and goes to S_SEED, discarding the accumulators.
  - If asserted in S_PUBLISH, the publish still completes that cycle.
  - clear has priority over sample_valid in the same cycle; that sample is dropped.
  - win_* outputs keep their last published values.
- saturating: registered on every valid sample as sat(sample_data). It holds when sample_valid = 0 and is unaffected by clear.
- sat_led:
  - The stretch counter reloads to STRETCH_CYCLES on any valid saturated sample; otherwise it decrements to 0.
  - sat_led = (counter != 0), registered. It rises 1 cycle after the saturated sample and falls STRETCH_CYCLES cycles after the last one.
  - Saturated samples arriving during the hold re-trigger the full hold.
- Window of all-equal samples gives win_min == win_max.
- Sample 16'h8000 is the most negative value, not positive.

Decomposition:
- Shared package holds:
  - SAT_POS / SAT_NEG constants derived from DATA_W
  - the FSM state typedef (S_SEED, S_ACCUM, S_PUBLISH)
  - an is_saturated function
- One sub-module: pulse_stretcher (parameter STRETCH_CYCLES; ports clk_50, reset, trigger, out). It drives sat_led and is reusable for other status LEDs.

Test Plan:
Bench uses WINDOW_LOG2=3, STRETCH_CYCLES=10.
1. Reset mid-window after 5 samples -> all outputs 0 immediately (asynchronous). The next 8 samples form a complete new window with win_valid after the 8th.
2. Samples 3, -7, 12, 0, 5, -2, 1, 4 back-to-back -> one cycle after the 8th, win_valid=1, win_min=-7, win_max=12, win_sat_count=0. Asserted for exactly one cycle.
3. A window containing 16'h7FFF, 16'h8000, 16'h8000 plus 5 zeros -> win_min=16'h8000, win_max=16'h7FFF, win_sat_count=3. saturating=1 after each saturated sample, 0 after the following zero.
4. 16 continuous valid samples -> two win_valid pulses exactly 8 cycles apart. The sample accepted during S_PUBLISH is counted in the second window, whose statistics match an independent model.
5. clear and sample_valid together after 4 samples -> that sample is dropped. The window publishes only after 8 further samples; the previous win_* are unchanged until then.
6. A single 16'h7FFF sample -> sat_led high 1 cycle later for 10 cycles. A second saturated sample 6 cycles in extends the high time to 10 cycles after it; sample_valid gaps do not affect the count.

Source files
------------

// File: rtl/adc_range_monitor_pkg.sv
// Shared definitions for the ADC range monitor: sample width, saturation codes,
// window FSM states and the saturation test.
package adc_range_monitor_pkg;

  localparam int ADC_DATA_W = 16;

  localparam logic [ADC_DATA_W-1:0] SAT_POS = {1'b0, {(ADC_DATA_W-1){1'b1}}};
  localparam logic [ADC_DATA_W-1:0] SAT_NEG = {1'b1, {(ADC_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_SEED    = 2'd0,
    S_ACCUM   = 2'd1,
    S_PUBLISH = 2'd2
  } state_e;

  function automatic logic is_saturated(input logic [ADC_DATA_W-1:0] sample);
    return (sample == SAT_POS) || (sample == SAT_NEG);
  endfunction

endpackage

// File: rtl/adc_range_monitor_pulse_stretcher.sv
// Retriggerable pulse stretcher: output stays high for STRETCH_CYCLES clocks
// after the most recent trigger.
module pulse_stretcher #(
  parameter int STRETCH_CYCLES = 5_000_000
) (
  input  logic clk_50,
  input  logic reset,
  input  logic trigger,
  output logic out
);

  localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // Registering the next-state compare gives exactly STRETCH_CYCLES high cycles.
    out_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/adc_range_monitor.sv
// Windowed signed min/max and saturation statistics for one ADC channel, plus an
// instantaneous saturation flag and a stretched saturation LED.
module adc_range_monitor
  import adc_range_monitor_pkg::*;
#(
  parameter int DATA_W         = ADC_DATA_W,
  parameter int WINDOW_LOG2    = 20,
  parameter int STRETCH_CYCLES = 5_000_000,
  parameter int SAT_CNT_W      = 16
) (
  input  logic                 clk_50,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    sample_data,
  input  logic                 clear,
  output logic [DATA_W-1:0]    win_min,
  output logic [DATA_W-1:0]    win_max,
  output logic [SAT_CNT_W-1:0] win_sat_count,
  output logic                 win_valid,
  output logic                 saturating,
  output logic                 sat_led
);

  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {WINDOW_LOG2{1'b1}}};

  state_e state_q, state_d;

  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] acc_min_q, acc_min_d;
  logic signed [DATA_W-1:0] acc_max_q, acc_max_d;
  logic [SAT_CNT_W-1:0]     acc_sat_q, acc_sat_d;
  logic [DATA_W-1:0]        win_min_q, win_min_d;
  logic [DATA_W-1:0]        win_max_q, win_max_d;
  logic [SAT_CNT_W-1:0]     win_sat_q, win_sat_d;
  logic                     win_valid_q, win_valid_d;
  logic                     saturating_q, saturating_d;

  logic                     sat;
  logic signed [DATA_W-1:0] sample_s;
  logic signed [DATA_W-1:0] upd_min, upd_max;
  logic [SAT_CNT_W-1:0]     upd_sat;

  assign sat      = is_saturated(sample_data);
  assign sample_s = sample_data;

  // Candidate accumulator values if the current sample joins a running window.
  assign upd_min = (sample_s < acc_min_q) ? sample_s : acc_min_q;
  assign upd_max = (sample_s > acc_max_q) ? sample_s : acc_max_q;
  assign upd_sat = (acc_sat_q == '1) ? acc_sat_q : acc_sat_q + SAT_CNT_W'(sat);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    acc_sat_d   = acc_sat_q;
    win_min_d   = win_min_q;
    win_max_d   = win_max_q;
    win_sat_d   = win_sat_q;
    win_valid_d = 1'b0;

    unique case (state_q)
      S_SEED, S_PUBLISH: begin
        // Publishing is already visible this cycle, so a sample here seeds the next window.
        if (clear) begin
          state_d = S_SEED;
          count_d = '0;
        end else if (sample_valid) begin
          state_d   = S_ACCUM;
          count_d   = CNT_W'(1);
          acc_min_d = sample_s;
          acc_max_d = sample_s;
          acc_sat_d = SAT_CNT_W'(sat);
        end else begin
          state_d = S_SEED;
          count_d = '0;
        end
      end
      S_ACCUM: begin
        if (clear) begin
          state_d = S_SEED;
          count_d = '0;
        end else if (sample_valid) begin
          count_d   = count_q + CNT_W'(1);
          acc_min_d = upd_min;
          acc_max_d = upd_max;
          acc_sat_d = upd_sat;
          if (count_q == LAST_IDX) begin
            state_d     = S_PUBLISH;
            win_min_d   = upd_min;
            win_max_d   = upd_max;
            win_sat_d   = upd_sat;
            win_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_SEED;
        count_d = '0;
      end
    endcase

    saturating_d = sample_valid ? sat : saturating_q;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_SEED;
      count_q      <= '0;
      acc_min_q    <= '0;
      acc_max_q    <= '0;
      acc_sat_q    <= '0;
      win_min_q    <= '0;
      win_max_q    <= '0;
      win_sat_q    <= '0;
      win_valid_q  <= 1'b0;
      saturating_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      acc_min_q    <= acc_min_d;
      acc_max_q    <= acc_max_d;
      acc_sat_q    <= acc_sat_d;
      win_min_q    <= win_min_d;
      win_max_q    <= win_max_d;
      win_sat_q    <= win_sat_d;
      win_valid_q  <= win_valid_d;
      saturating_q <= saturating_d;
    end
  end

  pulse_stretcher #(
    .STRETCH_CYCLES(STRETCH_CYCLES)
  ) u_sat_led (
    .clk_50 (clk_50),
    .reset  (reset),
    .trigger(sample_valid & sat),
    .out    (sat_led)
  );

  assign win_min       = win_min_q;
  assign win_max       = win_max_q;
  assign win_sat_count = win_sat_q;
  assign win_valid     = win_valid_q;
  assign saturating    = saturating_q;

endmodule

// File: tb/tb_adc_range_monitor.sv
// Directed self-checking bench for adc_range_monitor with an 8-sample window
// and a 10-cycle LED stretch.
module tb_adc_range_monitor;

  localparam int DW = 16;
  localparam int WL = 3;
  localparam int SC = 10;
  localparam int SW = 16;

  logic          clk_50 = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          clear = 1'b0;
  logic [DW-1:0] win_min;
  logic [DW-1:0] win_max;
  logic [SW-1:0] win_sat_count;
  logic          win_valid;
  logic          saturating;
  logic          sat_led;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk_50 = ~clk_50;

  adc_range_monitor #(
    .DATA_W(DW), .WINDOW_LOG2(WL), .STRETCH_CYCLES(SC), .SAT_CNT_W(SW)
  ) dut (
    .clk_50(clk_50), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .clear(clear), .win_min(win_min),
    .win_max(win_max), .win_sat_count(win_sat_count), .win_valid(win_valid),
    .saturating(saturating), .sat_led(sat_led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs at a falling edge, return at the next falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
    sample_valid = v;
    sample_data  = d;
    clear        = c;
    @(negedge clk_50);
    $display("t=%0t valid=%0b data=%h clear=%0b | win_valid=%0b min=%h max=%h sat_cnt=%0d saturating=%0b led=%0b",
             $time, v, d, c, win_valid, win_min, win_max, win_sat_count, saturating, sat_led);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_min"}, 32'(win_min), 32'd0);
    chk({tag, "_max"}, 32'(win_max), 32'd0);
    chk({tag, "_satcnt"}, 32'(win_sat_count), 32'd0);
    chk({tag, "_valid"}, 32'(win_valid), 32'd0);
    chk({tag, "_saturating"}, 32'(saturating), 32'd0);
    chk({tag, "_led"}, 32'(sat_led), 32'd0);
  endtask

  logic [DW-1:0] t2 [8] = '{16'd3, 16'hFFF9, 16'd12, 16'd0, 16'd5, 16'hFFFE, 16'd1, 16'd4};
  logic [DW-1:0] t3 [8] = '{16'h7FFF, 16'h8000, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [DW-1:0] t4 [16] = '{16'd5, 16'hFFFD, 16'd9, 16'd2, 16'd8, 16'hFFFF, 16'd0, 16'd7,
                             16'hFFEC, 16'd15, 16'h8000, 16'd4, 16'd4, 16'd100, 16'hFFCE, 16'd3};

  // Independent reference for one 8-sample slice of t4.
  task automatic model(input int base, output logic [DW-1:0] mn, output logic [DW-1:0] mx,
                       output logic [SW-1:0] sc);
    logic signed [DW-1:0] v;
    mn = 16'h7FFF;
    mx = 16'h8000;
    sc = '0;
    for (int k = 0; k < 8; k++) begin
      v = t4[base + k];
      if (v < $signed(mn)) mn = v;
      if (v > $signed(mx)) mx = v;
      if (v == 16'sh7FFF || v == 16'sh8000) sc = sc + 16'd1;
    end
  endtask

  initial begin
    logic [DW-1:0] emn, emx;
    logic [SW-1:0] esc;
    int p1, p2, np;

    // Power-on reset
    @(negedge clk_50);
    @(negedge clk_50);
    chk_all_zero("por");
    reset = 1'b0;

    // Mixed-sign window
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t2[i], 1'b0);
      if (i < 7) chk("t2_early_valid", 32'(win_valid), 32'd0);
    end
    chk("t2_valid", 32'(win_valid), 32'd1);
    chk("t2_min", 32'(win_min), 32'(16'hFFF9));
    chk("t2_max", 32'(win_max), 32'd12);
    chk("t2_satcnt", 32'(win_sat_count), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("t2_pulse_width", 32'(win_valid), 32'd0);
    chk("t2_hold_min", 32'(win_min), 32'(16'hFFF9));

    // Saturated extremes
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t3[i], 1'b0);
      if (i < 4) chk("t3_saturating", 32'(saturating), (i < 3) ? 32'd1 : 32'd0);
    end
    chk("t3_valid", 32'(win_valid), 32'd1);
    chk("t3_min", 32'(win_min), 32'(16'h8000));
    chk("t3_max", 32'(win_max), 32'(16'h7FFF));
    chk("t3_satcnt", 32'(win_sat_count), 32'd3);
    chk("t3_led_on", 32'(sat_led), 32'd1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0);
    chk("t3_led_off", 32'(sat_led), 32'd0);

    // Asynchronous reset mid-window
    step(1'b1, 16'd10, 1'b0);
    step(1'b1, 16'd20, 1'b0);
    step(1'b1, 16'd30, 1'b0);
    step(1'b1, 16'd40, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0);
    chk("t1_pre_saturating", 32'(saturating), 32'd1);
    chk("t1_pre_led", 32'(sat_led), 32'd1);
    sample_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all_zero("t1_async");
    @(negedge clk_50);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'(i + 1), 1'b0);
      if (i < 7) chk("t1_early_valid", 32'(win_valid), 32'd0);
    end
    chk("t1_valid", 32'(win_valid), 32'd1);
    chk("t1_min", 32'(win_min), 32'd1);
    chk("t1_max", 32'(win_max), 32'd8);
    chk("t1_satcnt", 32'(win_sat_count), 32'd0);
    step(1'b0, '0, 1'b0);

    // Back-to-back windows
    np = 0;
    p1 = -1;
    p2 = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, t4[i], 1'b0);
      if (win_valid) begin
        if (np == 0) p1 = i;
        else if (np == 1) p2 = i;
        np++;
      end
      if (i == 7) begin
        model(0, emn, emx, esc);
        chk("t4_w1_min", 32'(win_min), 32'(emn));
        chk("t4_w1_max", 32'(win_max), 32'(emx));
        chk("t4_w1_satcnt", 32'(win_sat_count), 32'(esc));
      end
    end
    model(8, emn, emx, esc);
    chk("t4_w2_min", 32'(win_min), 32'(emn));
    chk("t4_w2_max", 32'(win_max), 32'(emx));
    chk("t4_w2_satcnt", 32'(win_sat_count), 32'(esc));
    chk("t4_pulses", 32'(np), 32'd2);
    chk("t4_first_at", 32'(p1), 32'd7);
    chk("t4_gap", 32'(p2 - p1), 32'd8);
    step(1'b0, '0, 1'b0);

    // clear together with a valid sample
    for (int i = 0; i < 4; i++) step(1'b1, 16'(i + 1), 1'b0);
    step(1'b1, 16'd50, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'(i + 10), 1'b0);
      if (i < 7) chk("t5_early_valid", 32'(win_valid), 32'd0);
      if (i == 6) chk("t5_hold_min", 32'(win_min), 32'(emn));
    end
    chk("t5_valid", 32'(win_valid), 32'd1);
    chk("t5_min", 32'(win_min), 32'd10);
    chk("t5_max", 32'(win_max), 32'd17);
    chk("t5_satcnt", 32'(win_sat_count), 32'd0);
    step(1'b0, '0, 1'b0);

    // LED stretch and retrigger
    chk("t6_led_idle", 32'(sat_led), 32'd0);
    step(1'b1, 16'h7FFF, 1'b0);
    chk("t6_led_rise", 32'(sat_led), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      step((k % 3) == 0, 16'd1, 1'b0);
      chk("t6_single_hold", 32'(sat_led), (k < 10) ? 32'd1 : 32'd0);
    end
    step(1'b1, 16'h7FFF, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step((k % 2) == 0, 16'd2, 1'b0);
      chk("t6_pre_retrigger", 32'(sat_led), 32'd1);
    end
    step(1'b1, 16'h8000, 1'b0);
    chk("t6_retrigger", 32'(sat_led), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      step((k % 4) == 1, 16'd3, 1'b0);
      chk("t6_extended_hold", 32'(sat_led), (k < 10) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
